// File: rtl/lea_serial_sub.sv
// Digit-serial add/subtract: one DIGIT-bit slice per cycle, LSB slice first, valid/ready on both sides.
// Optional zero flag output ZF is built when LEA_SUB_ZFLAG_EN is defined.
module lea_serial_sub #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic             OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] D,
  output logic             Bout
`ifdef LEA_SUB_ZFLAG_EN
  ,
  output logic             ZF
`endif
);

  localparam int N  = WIDTH / DIGIT;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_q, b_q, d_q;
  logic             op_q, carry_q;
  logic             hs_in, last_slice;
  logic [DIGIT:0]   slice_res;
  logic [WIDTH+DIGIT-1:0] d_cat;

  assign IN_READY   = (state == IDLE) & ~RST;
  assign OUT_VALID  = (state == DONE);
  assign hs_in      = IN_VALID & IN_READY;
  assign last_slice = (idx == IW'(N - 1));

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (hs_in) state_nx = RUN;
      RUN:     if (last_slice) state_nx = DONE;
      DONE:    if (OUT_READY) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Top bit of the (DIGIT+1)-bit result is the carry (add) or borrow (subtract) into the next slice.
  always_comb begin
    slice_res = '0;
    if (op_q)
      slice_res = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
    else
      slice_res = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]} - {{DIGIT{1'b0}}, carry_q};
  end

  // Result slices enter at the top and shift down, so slice 0 lands at the LSB after N steps.
  assign d_cat = {slice_res[DIGIT-1:0], d_q};

  always_ff @(posedge CLK) begin
    if (RST) begin
      idx     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 1'b0;
      carry_q <= 1'b0;
      d_q     <= '0;
    end else if (hs_in) begin
      idx     <= '0;
      a_q     <= A;
      b_q     <= B;
      op_q    <= OP;
      carry_q <= Bin;
    end else if (state == RUN) begin
      idx     <= last_slice ? '0 : idx + IW'(1);
      a_q     <= a_q >> DIGIT;
      b_q     <= b_q >> DIGIT;
      carry_q <= slice_res[DIGIT];
      d_q     <= d_cat[WIDTH+DIGIT-1:DIGIT];
    end
  end

  assign D    = d_q;
  assign Bout = carry_q;

`ifdef LEA_SUB_ZFLAG_EN
  logic zf_q;

  always_ff @(posedge CLK) begin
    if (RST)                zf_q <= 1'b0;
    else if (hs_in)         zf_q <= 1'b1;
    else if (state == RUN)  zf_q <= zf_q & (slice_res[DIGIT-1:0] == '0);
  end

  assign ZF = zf_q;
`endif

endmodule

// File: tb/tb_lea_serial_sub.sv
// Scoreboard bench for lea_serial_sub (WIDTH=32, DIGIT=8): directed vectors, backpressure hold, mid-run reset.
module tb_lea_serial_sub;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic        OP = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        Bin = 1'b0;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b1;
  logic [31:0] D;
  logic        Bout;
`ifdef LEA_SUB_ZFLAG_EN
  logic        ZF;
`endif

  lea_serial_sub #(.WIDTH(32), .DIGIT(8)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .OP(OP),
    .A(A), .B(B), .Bin(Bin), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .D(D), .Bout(Bout)
`ifdef LEA_SUB_ZFLAG_EN
    , .ZF(ZF)
`endif
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] d;
    logic        bout;
    logic        zf;
    int          due;
  } exp_t;

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic [31:0] d;
    logic        bout;
  } vec_t;

  exp_t sb[$];
  exp_t e;
  vec_t vecs[10];
  int   n_checks = 0;
  int   n_fail = 0;
  logic prev_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got timeout/unexpected event expected none", name);
  endtask

  // Monitor: latency checked on the rising edge of OUT_VALID, data checked at the output handshake.
  always @(negedge CLK) begin
    if (OUT_VALID && !prev_valid) begin
      if (sb.size() == 0) flag("unexpected_out_valid");
      else chk("latency", 32'(cyc), 32'(sb[0].due));
    end
    if (OUT_VALID && OUT_READY && sb.size() > 0) begin
      e = sb.pop_front();
      chk("result_d", D, e.d);
      chk("result_bout", {31'b0, Bout}, {31'b0, e.bout});
`ifdef LEA_SUB_ZFLAG_EN
      chk("result_zf", {31'b0, ZF}, {31'b0, e.zf});
`endif
    end
    prev_valid = OUT_VALID;
  end

  task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] b, input logic bin,
                       input logic [31:0] ed, input logic eb, input logic push);
    int waited;
    exp_t x;
    waited = 0;
    OP = op; A = a; B = b; Bin = bin; IN_VALID = 1'b1;
    @(negedge CLK);
    while (!IN_READY && waited < 50) begin
      @(negedge CLK);
      waited++;
    end
    if (!IN_READY) begin
      flag("issue_timeout");
      IN_VALID = 1'b0;
      return;
    end
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    A = $urandom; B = $urandom; OP = 1'($urandom); Bin = 1'($urandom);
    if (push) begin
      x.d = ed; x.bout = eb; x.zf = (ed == 32'h0); x.due = cyc + 4;
      sb.push_back(x);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (sb.size() > 0) flag("drain_timeout");
    @(posedge CLK); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs = '{
      '{1'b0, 32'h00000005, 32'h00000003, 1'b0, 32'h00000002, 1'b0},
      '{1'b0, 32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1},
      '{1'b0, 32'h12345678, 32'h12345678, 1'b1, 32'hFFFFFFFF, 1'b1},
      '{1'b0, 32'h12345678, 32'h12345678, 1'b0, 32'h00000000, 1'b0},
      '{1'b1, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1},
      '{1'b1, 32'h0000FF00, 32'h00000100, 1'b1, 32'h00010001, 1'b0},
      '{1'b0, 32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFE, 1'b0},
      '{1'b1, 32'h12345678, 32'h87654321, 1'b0, 32'h99999999, 1'b0},
      '{1'b0, 32'h00000100, 32'h00000001, 1'b0, 32'h000000FF, 1'b0},
      '{1'b1, 32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0}
    };

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("reset_in_ready", {31'b0, IN_READY}, 32'h0);
    chk("reset_out_valid", {31'b0, OUT_VALID}, 32'h0);
    chk("reset_d", D, 32'h0);
    chk("reset_bout", {31'b0, Bout}, 32'h0);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    chk("ready_after_reset", {31'b0, IN_READY}, 32'h1);
    @(posedge CLK); #1;

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].d, vecs[i].bout, 1'b1);
      drain();
    end

    // Backpressure: result must hold in DONE while new operands are offered.
    OUT_READY = 1'b0;
    issue(1'b0, 32'h00001000, 32'h00000001, 1'b0, 32'h00000FFF, 1'b0, 1'b1);
    n = 0;
    @(negedge CLK);
    while (!OUT_VALID && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (!OUT_VALID) flag("hold_wait_timeout");
    for (int k = 0; k < 10; k++) begin
      @(posedge CLK); #1;
      IN_VALID = 1'b1; A = $urandom; B = $urandom; OP = 1'($urandom); Bin = 1'($urandom);
      @(negedge CLK);
      chk("hold_out_valid", {31'b0, OUT_VALID}, 32'h1);
      chk("hold_in_ready", {31'b0, IN_READY}, 32'h0);
      chk("hold_d", D, 32'h00000FFF);
      chk("hold_bout", {31'b0, Bout}, 32'h0);
    end
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    OUT_READY = 1'b1;
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("idle_after_accept_ready", {31'b0, IN_READY}, 32'h1);
    chk("idle_after_accept_valid", {31'b0, OUT_VALID}, 32'h0);
    chk("no_capture_during_hold", 32'(sb.size()), 32'h0);
    @(posedge CLK); #1;
    issue(1'b1, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1);
    drain();

    // Reset pulse in the second RUN cycle discards the operation.
    issue(1'b0, 32'h00000005, 32'h00000003, 1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge CLK); #1;
    RST = 1'b1;
    @(negedge CLK);
    chk("rst_in_ready_low", {31'b0, IN_READY}, 32'h0);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    chk("ready_after_midrun_rst", {31'b0, IN_READY}, 32'h1);
    chk("d_after_midrun_rst", D, 32'h0);
    chk("bout_after_midrun_rst", {31'b0, Bout}, 32'h0);
    repeat (8) @(negedge CLK);
    @(posedge CLK); #1;
    issue(1'b0, 32'h00000100, 32'h00000001, 1'b0, 32'h000000FF, 1'b0, 1'b1);
    drain();

    chk("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lea_serial_sub.md
LEA_SERIAL_SUB -- requirements
Module: lea_serial_sub

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand and result width in bits.
REQ-002 SHALL provide parameter DIGIT, default 8, bits processed per cycle; WIDTH SHALL be an integer multiple of DIGIT; N = WIDTH/DIGIT.
REQ-003 SHALL provide port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL provide port RST  input  1  synchronous active-high reset.
REQ-005 SHALL provide port IN_VALID  input  1  operands presented.
REQ-006 SHALL provide port IN_READY  output  1  block can accept operands.
REQ-007 SHALL provide port OP  input  1  0 = subtract, 1 = add; sampled at input handshake.
REQ-008 SHALL provide port A  input  WIDTH  minuend or addend.
REQ-009 SHALL provide port B  input  WIDTH  subtrahend or addend.
REQ-010 SHALL provide port Bin  input  1  borrow-in for subtract, carry-in for add.
REQ-011 SHALL provide port OUT_VALID  output  1  result available.
REQ-012 SHALL provide port OUT_READY  input  1  consumer accepts result.
REQ-013 SHALL provide port D  output  WIDTH  result.
REQ-014 SHALL provide port Bout  output  1  borrow-out for subtract, carry-out for add.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-016 IN_READY SHALL be 1 only in IDLE with RST low; input handshake = IN_VALID & IN_READY on a rising edge.
REQ-017 On input handshake, A, B, Bin, OP SHALL be registered and the FSM SHALL enter RUN with digit index 0 and the running borrow/carry set to Bin.
REQ-018 In RUN, each cycle SHALL process one DIGIT-bit slice, LSB slice first, propagating borrow/carry to the next slice; after slice N-1 the FSM SHALL enter DONE.
REQ-019 OUT_VALID SHALL assert exactly N cycles after the input-handshake edge and SHALL be 1 only in DONE.
REQ-020 Subtract: D = (A - B - Bin) mod 2^WIDTH; Bout = 1 iff A < B + Bin (unsigned).
REQ-021 Add: D = (A + B + Bin) mod 2^WIDTH; Bout = 1 iff A + B + Bin >= 2^WIDTH.
REQ-022 D and Bout SHALL be stable while OUT_VALID is 1; their values outside DONE are don't-care.
REQ-023 In DONE, OUT_VALID & OUT_READY on an edge SHALL return the FSM to IDLE; with OUT_READY low, DONE SHALL hold indefinitely.
REQ-024 IN_VALID in RUN or DONE SHALL be ignored; no operand queueing; input change after handshake SHALL not affect the result.
REQ-025 Operands changing while IN_READY is 0 SHALL have no effect.

Reset
REQ-026 RST high on an edge SHALL force IDLE, clear digit index, OUT_VALID = 0, D = 0, Bout = 0, regardless of state.
REQ-027 RST during RUN or DONE SHALL discard the operation; no OUT_VALID for it ever.
REQ-028 IN_READY SHALL be 0 while RST is high and 1 in the first cycle after RST deasserts.

Configuration
REQ-029 With macro LEA_SUB_ZFLAG_EN defined, SHALL add output ZF  output  1, equal to 1 iff D == 0, valid with OUT_VALID, reset to 0, accumulated per slice with no extra latency.
REQ-030 Without LEA_SUB_ZFLAG_EN, port ZF and its logic SHALL be absent; all other behaviour identical.

Verification (WIDTH=32, DIGIT=8, N=4)
REQ-031 Sub A=0x00000005 B=0x00000003 Bin=0 -> D=0x00000002, Bout=0, OUT_VALID exactly 4 cycles after handshake.
REQ-032 Sub A=0x00000000 B=0x00000001 Bin=0 -> D=0xFFFFFFFF, Bout=1 (wrap-around).
REQ-033 Sub A=B=0x12345678 Bin=1 -> D=0xFFFFFFFF, Bout=1; same with Bin=0 -> D=0x00000000, Bout=0, ZF=1 when LEA_SUB_ZFLAG_EN defined.
REQ-034 Add A=0xFFFFFFFF B=0x00000001 Bin=0 -> D=0x00000000, Bout=1; add A=0x0000FF00 B=0x00000100 Bin=1 -> D=0x00010001, Bout=0.
REQ-035 OUT_READY held low 10 cycles in DONE with IN_VALID high -> OUT_VALID, D, Bout held, IN_READY=0, no new capture; OUT_READY=1 -> IDLE next cycle, new operands then accepted.
REQ-036 RST pulsed 1 cycle at second RUN cycle -> OUT_VALID stays 0, IN_READY=1 the cycle after release, next operation yields correct result.
